// File: rtl/ff_pkg.sv
// Shared constants for the feed-forward weight path.
// Layer encodings, default bus widths, float constants.
package ff_pkg;

  localparam int DATA_WIDTH_DEF        = 32;
  localparam int LAYER_WIDTH_DEF       = 2;
  localparam int WEIGHT_ADDR_WIDTH_DEF = 11;

  typedef enum logic [LAYER_WIDTH_DEF-1:0] {
    INPUT    = 2'd0,
    HIDDEN_1 = 2'd1,
    HIDDEN_2 = 2'd2,
    OUTPUT   = 2'd3
  } layer_e;

  localparam logic [31:0] ONE = 32'h3F80_0000;

endpackage

// File: rtl/req_fifo.sv
// Synchronous read-request FIFO, power-of-2 depth.
// Ports: push/pop strobes, data in/out (head), count, empty/full.
module req_fifo
  import ff_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == DEPTH_C);
  assign o_count = cnt_q;
  assign o_data  = mem_q[rd_ptr_q];

  always_comb begin
    // A push into a full FIFO is legal only when
    // the head leaves in the same cycle.
    do_push  = i_push && (!o_full || i_pop);
    do_pop   = i_pop && !o_empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/weight_mem_arbiter.sv
// Arbitrates feed-forward reads and weight-update writes onto one
// single-port weight memory. Ports: i_rd_* read req, i_wr_*/o_wr_ready
// write req, o_mem_*/i_mem_rdata memory, o_rd_* response, o_overflow.
module weight_mem_arbiter
  import ff_pkg::*;
#(
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int LAYER_WIDTH       = LAYER_WIDTH_DEF,
  parameter int WEIGHT_ADDR_WIDTH = WEIGHT_ADDR_WIDTH_DEF,
  parameter int READ_LATENCY      = 2,
  parameter int FIFO_DEPTH        = 4,
  parameter int MAX_READ_BURST    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rd_valid,
  input  logic [LAYER_WIDTH-1:0]       i_rd_layer,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                         i_wr_valid,
  input  logic [LAYER_WIDTH-1:0]       i_wr_layer,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  output logic                         o_wr_ready,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [LAYER_WIDTH-1:0]       o_mem_layer,
  output logic [WEIGHT_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]        o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]        i_mem_rdata,
  output logic                         o_rd_valid,
  output logic [LAYER_WIDTH-1:0]       o_rd_layer,
  output logic [WEIGHT_ADDR_WIDTH-1:0] o_rd_addr,
  output logic [DATA_WIDTH-1:0]        o_rd_data,
  output logic                         o_overflow
);

  localparam int AW = WEIGHT_ADDR_WIDTH;
  localparam int TW = LAYER_WIDTH + AW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(MAX_READ_BURST + 2);
  localparam int L  = READ_LATENCY;
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_READ_BURST);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  logic [TW-1:0] in_tag, rd_tag, fifo_dout;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic          have_rd, wr_grant, rd_grant;
  logic          push, pop;

  logic [SW-1:0]          starve_q, starve_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [LAYER_WIDTH-1:0] mem_layer_q, mem_layer_d;
  logic [AW-1:0]          mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [L-1:0]           sr_vld_q, sr_vld_d;
  logic [L-1:0][TW-1:0]   sr_tag_q, sr_tag_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [TW-1:0]          rd_tag_q, rd_tag_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   ovf_q, ovf_d;

  assign in_tag = {i_rd_layer, i_rd_addr};

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TW)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (in_tag),
    .o_data  (fifo_dout),
    .o_count (fifo_cnt),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  always_comb begin
    // Queued reads go first so responses stay in request order.
    have_rd  = !fifo_empty || i_rd_valid;
    rd_tag   = fifo_empty ? in_tag : fifo_dout;
    // A write may only jump a read if that read has room to wait.
    wr_grant = i_wr_valid &&
               (!have_rd ||
                (starve_q >= STARVE_MAX && fifo_cnt < DEPTH_C));
    rd_grant = have_rd && !wr_grant;
    pop      = rd_grant && !fifo_empty;
    // Any incoming read not consumed by the bypass path waits.
    push     = i_rd_valid && !(rd_grant && fifo_empty);
    ovf_d    = ovf_q || (push && fifo_full && !pop);

    starve_d = starve_q;
    if (!i_wr_valid || wr_grant) begin
      starve_d = '0;
    end else if (rd_grant && starve_q < STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    mem_en_d    = wr_grant || rd_grant;
    mem_we_d    = wr_grant;
    mem_layer_d = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (wr_grant) begin
      mem_layer_d = i_wr_layer;
      mem_addr_d  = i_wr_addr;
      mem_wdata_d = i_wr_data;
    end else if (rd_grant) begin
      mem_layer_d = rd_tag[TW-1:AW];
      mem_addr_d  = rd_tag[AW-1:0];
    end

    // Tag pipe aligned so its last stage meets i_mem_rdata.
    sr_vld_d[0] = mem_en_q && !mem_we_q;
    sr_tag_d[0] = {mem_layer_q, mem_addr_q};
    for (int i = 1; i < L; i++) begin
      sr_vld_d[i] = sr_vld_q[i-1];
      sr_tag_d[i] = sr_tag_q[i-1];
    end

    rd_valid_d = sr_vld_q[L-1];
    rd_tag_d   = rd_tag_q;
    rd_data_d  = rd_data_q;
    if (sr_vld_q[L-1]) begin
      rd_tag_d  = sr_tag_q[L-1];
      rd_data_d = i_mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_layer_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sr_vld_q    <= '0;
      sr_tag_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_tag_q    <= '0;
      rd_data_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_layer_q <= mem_layer_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sr_vld_q    <= sr_vld_d;
      sr_tag_q    <= sr_tag_d;
      rd_valid_q  <= rd_valid_d;
      rd_tag_q    <= rd_tag_d;
      rd_data_q   <= rd_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_wr_ready  = wr_grant;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_layer = mem_layer_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_layer  = rd_tag_q[TW-1:AW];
  assign o_rd_addr   = rd_tag_q[AW-1:0];
  assign o_rd_data   = rd_data_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// Self-checking bench for weight_mem_arbiter.
// Scoreboard of expected responses plus per-scenario tasks.
module tb_weight_mem_arbiter;
  import ff_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_valid = 0, wr_valid = 0;
  logic [1:0]  rd_layer = 0, wr_layer = 0;
  logic [10:0] rd_addr = 0, wr_addr = 0;
  logic [31:0] wr_data = 0, mem_rdata = 0;
  logic        wr_ready, mem_en, mem_we;
  logic [1:0]  mem_layer, ord_layer;
  logic [10:0] mem_addr, ord_addr;
  logic [31:0] mem_wdata, ord_data;
  logic        ord_valid, overflow;

  logic        z_rd_valid = 0, z_wr_valid = 0;
  logic [10:0] z_rd_addr = 0, z_wr_addr = 0;
  logic [1:0]  z_zero2 = 0;
  logic [31:0] z_zero32 = 0;
  logic        z_wr_ready, z_mem_en, z_mem_we;
  logic [1:0]  z_mem_layer, z_ord_layer;
  logic [10:0] z_mem_addr, z_ord_addr;
  logic [31:0] z_mem_wdata, z_ord_data;
  logic        z_ord_valid, z_overflow;

  typedef struct {
    logic [1:0]  layer;
    logic [10:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          q0[$];
  exp_t        e;
  int          checks = 0, errors = 0;
  int          n_resp = 0, n_resp0 = 0;
  logic [31:0] mem [4][2048];
  logic [31:0] exp_mem [4][2048];
  logic [31:0] pipe [0:LAT];

  always #5 clk = ~clk;

  weight_mem_arbiter #(.READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_rd_valid(rd_valid), .i_rd_layer(rd_layer), .i_rd_addr(rd_addr),
    .i_wr_valid(wr_valid), .i_wr_layer(wr_layer), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_layer(mem_layer),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_rd_valid(ord_valid), .o_rd_layer(ord_layer),
    .o_rd_addr(ord_addr), .o_rd_data(ord_data),
    .o_overflow(overflow)
  );

  weight_mem_arbiter #(.READ_LATENCY(LAT), .MAX_READ_BURST(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_rd_valid(z_rd_valid), .i_rd_layer(z_zero2),
    .i_rd_addr(z_rd_addr),
    .i_wr_valid(z_wr_valid), .i_wr_layer(z_zero2),
    .i_wr_addr(z_wr_addr), .i_wr_data(z_zero32),
    .o_wr_ready(z_wr_ready),
    .o_mem_en(z_mem_en), .o_mem_we(z_mem_we),
    .o_mem_layer(z_mem_layer), .o_mem_addr(z_mem_addr),
    .o_mem_wdata(z_mem_wdata), .i_mem_rdata(z_zero32),
    .o_rd_valid(z_ord_valid), .o_rd_layer(z_ord_layer),
    .o_rd_addr(z_ord_addr), .o_rd_data(z_ord_data),
    .o_overflow(z_overflow)
  );

  // Memory model, response monitors.
  always @(negedge clk) begin
    if (mem_en && mem_we) mem[mem_layer][mem_addr] = mem_wdata;
    for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = (mem_en && !mem_we) ? mem[mem_layer][mem_addr] : 32'h0;
    mem_rdata = pipe[LAT];

    if (!rst && ord_valid) begin
      n_resp++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got L%0d A%0d D%h, required none",
                 ord_layer, ord_addr, ord_data);
      end else begin
        e = sbq.pop_front();
        if ({ord_layer, ord_addr, ord_data} !==
            {e.layer, e.addr, e.data}) begin
          errors++;
          $display("FAIL resp: got L%0d A%0d D%h, required L%0d A%0d D%h",
                   ord_layer, ord_addr, ord_data,
                   e.layer, e.addr, e.data);
        end
      end
    end

    if (!rst && z_ord_valid) begin
      n_resp0++;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL resp0_unexpected: got A%0d, required none",
                 z_ord_addr);
      end else if (32'(z_ord_addr) !== q0[0]) begin
        errors++;
        $display("FAIL resp0: got A%0d, required A%0d",
                 z_ord_addr, q0[0]);
        void'(q0.pop_front());
      end else begin
        void'(q0.pop_front());
      end
    end
  end

  task automatic drive_rd(input logic [1:0] l, input logic [10:0] a);
    rd_valid = 1'b1;
    rd_layer = l;
    rd_addr  = a;
    sbq.push_back('{l, a, exp_mem[l][a]});
  endtask

  task automatic wait_drain(input string name, input int bound);
    int c = 0;
    while ((sbq.size() != 0 || q0.size() != 0) && c < bound) begin
      @(posedge clk);
      c++;
    end
    #1;
    checks++;
    if (sbq.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d/%0d pending, required 0",
               name, sbq.size(), q0.size());
      sbq.delete();
      q0.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_en, mem_we, ord_valid, overflow, wr_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {mem_en, mem_we, ord_valid, overflow, wr_ready});
    end
    checks++;
    if ({mem_addr, mem_wdata, ord_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h, required 0",
               mem_addr, mem_wdata, ord_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    drive_rd(2'd1, 11'd5);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_layer, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 2'd1, 11'd5, 32'h0}) begin
      errors++;
      $display("FAIL single_cmd: got en%b we%b L%0d A%0d, required 1 0 1 5",
               mem_en, mem_we, mem_layer, mem_addr);
    end
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ord_valid !== (k == 4)) begin
        errors++;
        $display("FAIL single_latency: T+%0d got %b, required %b",
                 k, ord_valid, (k == 4));
      end
    end
    wait_drain("single", 10);
  endtask

  task automatic test_back_to_back();
    int n0 = n_resp;
    for (int i = 0; i < 99; i++) begin
      @(posedge clk); #1;
      drive_rd(2'd1, 11'(i));
    end
    @(posedge clk); #1;
    rd_valid = 1'b0;
    wait_drain("stream", 40);
    checks++;
    if (n_resp - n0 != 99) begin
      errors++;
      $display("FAIL stream_count: got %0d, required 99", n_resp - n0);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL stream_ovf: got %b, required 0", overflow);
    end
  endtask

  task automatic test_starvation();
    int n0 = n_resp;
    int ready_at = -1;
    wr_valid = 1'b1;
    wr_layer = 2'd3;
    wr_addr  = 11'd100;
    wr_data  = 32'h1234_5678;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ready_at >= 0) wr_valid = 1'b0;
      drive_rd(2'd2, 11'(300 + i));
      #1;
      if (wr_valid && wr_ready) begin
        if (ready_at < 0) ready_at = i;
        exp_mem[3][100] = 32'h1234_5678;
      end
    end
    @(posedge clk); #1;
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (ready_at != 8) begin
      errors++;
      $display("FAIL starve_grant: got read grants %0d, required 8",
               ready_at);
    end
    wait_drain("starve", 30);
    checks++;
    if (n_resp - n0 != 20) begin
      errors++;
      $display("FAIL starve_count: got %0d, required 20", n_resp - n0);
    end
    @(posedge clk); #1;
    drive_rd(2'd3, 11'd100);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    wait_drain("starve_rb", 10);
  endtask

  task automatic test_write_then_read();
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_layer = 2'd2;
    wr_addr  = 11'd7;
    wr_data  = 32'h4000_0000;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_idle: got %b, required 1", wr_ready);
    end
    exp_mem[2][7] = 32'h4000_0000;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    drive_rd(2'd2, 11'd7);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 11'd7, 32'h4000_0000}) begin
      errors++;
      $display("FAIL wr_cmd: got en%b we%b A%0d D%h, required 1 1 7 40000000",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rd_valid = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 11'd7}) begin
      errors++;
      $display("FAIL rd_after_wr_cmd: got en%b we%b A%0d, required 1 0 7",
               mem_en, mem_we, mem_addr);
    end
    wait_drain("wr_rd", 10);
  endtask

  task automatic test_fifo_full();
    int accepted = 0;
    z_wr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (accepted >= 5) z_wr_valid = 1'b0;
      z_wr_addr  = 11'(accepted);
      z_rd_valid = (i < 5);
      z_rd_addr  = 11'(i);
      if (i < 5) q0.push_back(i);
      #1;
      if (i == 4) begin
        checks++;
        if (z_wr_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_inhibit: got %b, required 0", z_wr_ready);
        end
      end
      if (z_wr_valid && z_wr_ready) accepted++;
    end
    z_wr_valid = 1'b0;
    z_rd_valid = 1'b0;
    wait_drain("full", 20);
    checks++;
    if (accepted != 5) begin
      errors++;
      $display("FAIL full_writes: got %0d, required 5", accepted);
    end
    checks++;
    if (z_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_ovf: got %b, required 0", z_overflow);
    end
  endtask

  task automatic test_reset_inflight();
    int n0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_rd(2'd0, 11'(40 + i));
    end
    @(posedge clk); #1;
    rd_valid = 1'b0;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({mem_en, mem_we, ord_valid, overflow, mem_addr, ord_data} !== '0) begin
      errors++;
      $display("FAIL rst_flight: got en%b we%b v%b A%0d D%h, required 0",
               mem_en, mem_we, ord_valid, mem_addr, ord_data);
    end
    n0 = n_resp;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_resp != n0) begin
      errors++;
      $display("FAIL rst_ghost: got %0d responses, required 0",
               n_resp - n0);
    end
    @(posedge clk); #1;
    drive_rd(2'd3, 11'd9);
    @(posedge clk); #1;
    rd_valid = 1'b0;
    wait_drain("rst_new", 10);
    checks++;
    if (n_resp != n0 + 1) begin
      errors++;
      $display("FAIL rst_new_count: got %0d, required 1", n_resp - n0);
    end
  endtask

  initial begin
    for (int l = 0; l < 4; l++) begin
      for (int a = 0; a < 2048; a++) begin
        mem[l][a]     = 32'hC000_0000 | 32'(l << 16) | 32'(a);
        exp_mem[l][a] = 32'hC000_0000 | 32'(l << 16) | 32'(a);
      end
    end
    mem[1][5]     = ONE;
    exp_mem[1][5] = 32'h3F80_0000;
    for (int i = 0; i <= LAT; i++) pipe[i] = 32'h0;

    test_reset();
    test_single_read();
    test_back_to_back();
    test_starvation();
    test_write_then_read();
    test_fifo_full();
    test_reset_inflight();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weight_mem_arbiter.md
WEIGHT_MEM_ARBITER -- requirements
Module: weight_mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 32, weight word width (IEEE-754 single) | LAYER_WIDTH, 2, layer select width | WEIGHT_ADDR_WIDTH, 11, weight address width | READ_LATENCY, 2, memory read latency in cycles (1..4) | FIFO_DEPTH, 4, read-request buffer depth (power of 2) | MAX_READ_BURST, 8, consecutive read grants allowed while a write waits.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, sole clock | rst, in, 1, synchronous active-high reset.
REQ-003 i_rd_valid, in, 1, feed-forward weight read request (no backpressure; always accepted).
REQ-004 i_rd_layer, in, LAYER_WIDTH, layer of read | i_rd_addr, in, WEIGHT_ADDR_WIDTH, address of read.
REQ-005 i_wr_valid, in, 1, weight-update write request | i_wr_layer, in, LAYER_WIDTH | i_wr_addr, in, WEIGHT_ADDR_WIDTH | i_wr_data, in, DATA_WIDTH.
REQ-006 o_wr_ready, out, 1, write accepted this cycle (combinational from grant).
REQ-007 o_mem_en, out, 1 | o_mem_we, out, 1 | o_mem_layer, out, LAYER_WIDTH | o_mem_addr, out, WEIGHT_ADDR_WIDTH | o_mem_wdata, out, DATA_WIDTH: registered single-port memory command.
REQ-008 i_mem_rdata, in, DATA_WIDTH, read data valid READ_LATENCY cycles after a read command is visible on o_mem_*.
REQ-009 o_rd_valid, out, 1 | o_rd_layer, out, LAYER_WIDTH | o_rd_addr, out, WEIGHT_ADDR_WIDTH | o_rd_data, out, DATA_WIDTH: registered read response to feed_forward.
REQ-010 o_overflow, out, 1, sticky read-FIFO overflow error.

Function
REQ-011 Read source each cycle: FIFO head if FIFO non-empty, else incoming i_rd_* (bypass).
REQ-012 Write grant when i_wr_valid and (no read source, or (starve_cnt >= MAX_READ_BURST and FIFO count < FIFO_DEPTH)); otherwise read source (if any) is granted.
REQ-013 On write grant, a concurrent i_rd_valid request is pushed into the FIFO; o_wr_ready = 1 that cycle only.
REQ-014 On read grant from FIFO head, head is popped and a concurrent i_rd_valid request is pushed (simultaneous push/pop keeps count unchanged).
REQ-015 starve_cnt: +1 per read grant while i_wr_valid = 1, saturating at MAX_READ_BURST; cleared on write grant or when i_wr_valid = 0.
REQ-016 Grant registered to o_mem_* at next edge; o_mem_en = 1 for any grant; o_mem_we = 1 only for write; o_mem_wdata = 0 on reads.
REQ-017 Read tag (layer, addr) delayed through a READ_LATENCY-deep valid/tag shift register; o_rd_* registered with i_mem_rdata when tag emerges.
REQ-018 Latency: bypass read, no contention, request at cycle T -> o_rd_valid at T+2+READ_LATENCY.
REQ-019 Responses return in request order, one per cycle max; reads never dropped unless overflow.
REQ-020 Push with FIFO full and no pop: request dropped, o_overflow set and held until reset.
REQ-021 Write and read to same layer/address: memory access order equals grant order (single port, no reordering).
REQ-022 Write data/addr held stable by requester while i_wr_valid = 1 and o_wr_ready = 0.

Reset
REQ-023 rst sampled on clk rising edge only; all outputs, FIFO pointers/count, starve_cnt and shift register cleared to 0.
REQ-024 Reset mid-operation discards queued and in-flight reads; no o_rd_valid issued for them after reset release.

Structure
REQ-025 Shared package ff_pkg holds layer encodings (INPUT=0, HIDDEN_1=1, HIDDEN_2=2, OUTPUT=3), DATA_WIDTH/LAYER_WIDTH/WEIGHT_ADDR_WIDTH defaults, float constant ONE=32'h3F800000.
REQ-026 One sub-module: req_fifo (synchronous FIFO, FIFO_DEPTH x (LAYER_WIDTH+WEIGHT_ADDR_WIDTH), count output, bypass handled in arbiter).

Verification
REQ-027 Single read layer 1 addr 5, mem returns 32'h3F800000 -> o_rd_valid at T+4, layer 1, addr 5, data 32'h3F800000.
REQ-028 99 back-to-back reads (layer 1, addr 0..98), no writes -> 99 in-order responses, addr 0..98 consecutive, o_overflow = 0.
REQ-029 Write held during continuous read stream -> o_wr_ready after exactly 8 read grants; following reads delayed 1 cycle via FIFO, all returned in order.
REQ-030 Write layer 2 addr 7 data 32'h40000000, then read layer 2 addr 7 -> o_mem_we pulse precedes read; response data 32'h40000000.
REQ-031 Force FIFO full (MAX_READ_BURST=0, 5 writes queued against reads) -> write grant inhibited at count 4; o_overflow stays 0.
REQ-032 rst asserted with 3 reads in flight -> all outputs 0 next cycle; no o_rd_valid after release until new request.
